// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit CPU: opcode field constants,
// instruction-class helpers and the fetch-stage state encoding.
package cpu_pkg;

  localparam logic [3:0] OP_BR   = 4'b1100;
  localparam logic [3:0] OP_JMP  = 4'b1101;
  localparam logic [3:0] OP_JMPI = 4'b1110;
  localparam logic [3:0] OP_CALL = 4'b1111;

  typedef enum logic [1:0] {
    IDLE,
    FETCH_OP,
    FETCH_IMM,
    ISSUE
  } fetch_state_e;

  // Opcodes that carry a second (immediate) word.
  function automatic logic is_two_word(input logic [3:0] op);
    logic r;
    r = 1'b0;
    unique case (1'b1)
      (op == OP_JMPI): r = 1'b1;
      (op == OP_CALL): r = 1'b1;
      default:         r = 1'b0;
    endcase
    return r;
  endfunction

  // Opcodes whose successor IP comes from the branch target.
  function automatic logic is_ctrl(input logic [3:0] op);
    logic r;
    r = 1'b0;
    unique case (1'b1)
      (op == OP_BR):   r = 1'b1;
      (op == OP_JMP):  r = 1'b1;
      (op == OP_JMPI): r = 1'b1;
      (op == OP_CALL): r = 1'b1;
      default:         r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/instr_fetch.sv
// Instruction fetch / program-counter stage: fetches 1- or 2-word
// instructions over req/ack, issues them, commits the next IP.
// Ports:
//   clk, rst              clock, async active-high reset
//   mem_req/addr/ack/rdata program-memory read handshake
//   ip, opcode, imm       issued instruction and its address
//   instr_valid           issued instruction valid for execute
//   exec_done             execute finished with issued instruction
//   next_ip, next_ip2     branch target and sequential IP
module instr_fetch
  import cpu_pkg::*;
#(
  parameter logic [15:0] RESET_VECTOR = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  input  logic        mem_ack,
  input  logic [15:0] mem_rdata,
  output logic [15:0] ip,
  output logic [15:0] opcode,
  output logic [15:0] imm,
  output logic        instr_valid,
  input  logic        exec_done,
  input  logic [15:0] next_ip,
  input  logic [15:0] next_ip2
);

  fetch_state_e state;

  logic [15:0] ip_inc;
  logic [15:0] commit_ip;

  // Immediate word sits directly after the opcode; wraps at 64K.
  assign ip_inc = ip + 16'd1;

  assign commit_ip = is_ctrl(opcode[15:12]) ? next_ip
                                            : next_ip2;

  // Outputs are registered alongside the state so they
  // depend on no input combinationally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      ip          <= RESET_VECTOR;
      opcode      <= 16'h0000;
      imm         <= 16'h0000;
      instr_valid <= 1'b0;
      mem_req     <= 1'b0;
      mem_addr    <= RESET_VECTOR;
    end else begin
      unique case (state)
        IDLE: begin
          state    <= FETCH_OP;
          mem_req  <= 1'b1;
          mem_addr <= ip;
        end
        FETCH_OP: begin
          if (mem_ack) begin
            opcode <= mem_rdata;
            if (is_two_word(mem_rdata[15:12])) begin
              state    <= FETCH_IMM;
              mem_addr <= ip_inc;
            end else begin
              state       <= ISSUE;
              imm         <= 16'h0000;
              mem_req     <= 1'b0;
              instr_valid <= 1'b1;
            end
          end
        end
        FETCH_IMM: begin
          if (mem_ack) begin
            state       <= ISSUE;
            imm         <= mem_rdata;
            mem_req     <= 1'b0;
            mem_addr    <= ip;
            instr_valid <= 1'b1;
          end
        end
        ISSUE: begin
          if (exec_done) begin
            state       <= FETCH_OP;
            ip          <= commit_ip;
            mem_addr    <= commit_ip;
            mem_req     <= 1'b1;
            instr_valid <= 1'b0;
          end
        end
        default: begin
          state       <= IDLE;
          mem_req     <= 1'b0;
          instr_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed table of
// instructions, reset abort sequence, then randomized traffic.
module tb_instr_fetch;

  logic        clk;
  logic        rst;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic [15:0] ip;
  logic [15:0] opcode;
  logic [15:0] imm;
  logic        instr_valid;
  logic        exec_done;
  logic [15:0] next_ip;
  logic [15:0] next_ip2;

  localparam logic [15:0] RV = 16'h0100;

  instr_fetch #(.RESET_VECTOR(RV)) dut (
    .clk(clk),
    .rst(rst),
    .mem_req(mem_req),
    .mem_addr(mem_addr),
    .mem_ack(mem_ack),
    .mem_rdata(mem_rdata),
    .ip(ip),
    .opcode(opcode),
    .imm(imm),
    .instr_valid(instr_valid),
    .exec_done(exec_done),
    .next_ip(next_ip),
    .next_ip2(next_ip2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk;
  int n_fail;

  logic [15:0] cur_op;
  logic [15:0] cur_imm;

  typedef struct {
    logic [15:0] w0;
    logic [15:0] w1;
    logic [15:0] exp_imm;
    logic [15:0] nip;
    logic [15:0] nip2;
    logic [15:0] exp_next;
    int          wait0;
    int          wait1;
    int          edelay;
  } vec_t;

  vec_t tbl [9];

  task automatic chk(input string nm,
                     input logic [15:0] act,
                     input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Entered just after a negedge where the DUT must already be
  // requesting addr; serves the word after the given wait states.
  task automatic fetch_word(input string nm,
                            input logic [15:0] addr,
                            input logic [15:0] data,
                            input int waits,
                            input logic op_word);
    chk({nm, ".req"}, {15'd0, mem_req}, 16'd1);
    chk({nm, ".addr"}, mem_addr, addr);
    chk({nm, ".valid"}, {15'd0, instr_valid}, 16'd0);
    for (int w = 0; w < waits; w++) begin
      mem_ack   = 1'b0;
      exec_done = 1'($urandom_range(0, 1));
      next_ip   = 16'($urandom);
      next_ip2  = 16'($urandom);
      mem_rdata = 16'($urandom);
      @(negedge clk);
      chk({nm, ".wreq"}, {15'd0, mem_req}, 16'd1);
      chk({nm, ".waddr"}, mem_addr, addr);
      chk({nm, ".wvalid"}, {15'd0, instr_valid}, 16'd0);
      chk({nm, ".wop"}, opcode, cur_op);
      chk({nm, ".wimm"}, imm, cur_imm);
    end
    exec_done = 1'b0;
    mem_ack   = 1'b1;
    mem_rdata = data;
    @(negedge clk);
    mem_ack   = 1'b0;
    mem_rdata = 16'($urandom);
    if (op_word) cur_op = data;
    else cur_imm = data;
  endtask

  task automatic run_instr(input string nm,
                           input logic [15:0] addr,
                           input logic [15:0] w0,
                           input logic [15:0] w1,
                           input logic [15:0] exp_imm,
                           input logic [15:0] nip,
                           input logic [15:0] nip2,
                           input int wait0,
                           input int wait1,
                           input int edelay);
    logic two;
    logic [15:0] a1;
    two = (w0[15:12] == 4'hE) || (w0[15:12] == 4'hF);
    a1  = addr + 16'd1;
    chk({nm, ".ip0"}, ip, addr);
    fetch_word({nm, ".op"}, addr, w0, wait0, 1'b1);
    if (two) fetch_word({nm, ".imm"}, a1, w1, wait1, 1'b0);
    else cur_imm = 16'h0000;
    chk({nm, ".ivalid"}, {15'd0, instr_valid}, 16'd1);
    chk({nm, ".ireq"}, {15'd0, mem_req}, 16'd0);
    chk({nm, ".iop"}, opcode, w0);
    chk({nm, ".iimm"}, imm, exp_imm);
    chk({nm, ".iip"}, ip, addr);
    for (int d = 0; d < edelay; d++) begin
      mem_ack   = 1'($urandom_range(0, 1));
      mem_rdata = 16'($urandom);
      next_ip   = 16'($urandom);
      next_ip2  = 16'($urandom);
      @(negedge clk);
      chk({nm, ".hvalid"}, {15'd0, instr_valid}, 16'd1);
      chk({nm, ".hreq"}, {15'd0, mem_req}, 16'd0);
      chk({nm, ".hop"}, opcode, w0);
    end
    mem_ack   = 1'b0;
    exec_done = 1'b1;
    next_ip   = nip;
    next_ip2  = nip2;
    @(negedge clk);
    exec_done = 1'b0;
    next_ip   = 16'($urandom);
    next_ip2  = 16'($urandom);
  endtask

  logic [15:0] pc;

  initial begin
    n_chk     = 0;
    n_fail    = 0;
    cur_op    = 16'h0000;
    cur_imm   = 16'h0000;
    rst       = 1'b1;
    mem_ack   = 1'b0;
    mem_rdata = 16'h0000;
    exec_done = 1'b0;
    next_ip   = 16'h0000;
    next_ip2  = 16'h0000;

    tbl[0] = '{16'h1234, 16'hBEEF, 16'h0000, 16'h0777, 16'h0101,
               16'h0101, 0, 0, 0};
    tbl[1] = '{16'hC912, 16'hBEEF, 16'h0000, 16'h0050, 16'h0102,
               16'h0050, 1, 0, 1};
    tbl[2] = '{16'h2345, 16'hBEEF, 16'h0000, 16'h0050, 16'h0011,
               16'h0011, 0, 0, 0};
    tbl[3] = '{16'hE000, 16'h0ABC, 16'h0ABC, 16'h0ABC, 16'h0012,
               16'h0ABC, 3, 2, 0};
    tbl[4] = '{16'hD001, 16'hBEEF, 16'h0000, 16'hFFFF, 16'h0ABD,
               16'hFFFF, 0, 0, 0};
    tbl[5] = '{16'hF000, 16'h5555, 16'h5555, 16'h0200, 16'h0000,
               16'h0200, 0, 0, 0};
    tbl[6] = '{16'hDABC, 16'hBEEF, 16'h0000, 16'hFFFF, 16'h0201,
               16'hFFFF, 0, 0, 0};
    tbl[7] = '{16'h1000, 16'hBEEF, 16'h0000, 16'h1234, 16'h0000,
               16'h0000, 0, 0, 2};
    tbl[8] = '{16'h5555, 16'hBEEF, 16'h0000, 16'h0300, 16'h0001,
               16'h0001, 2, 0, 0};

    @(negedge clk);
    @(negedge clk);
    chk("rst.req", {15'd0, mem_req}, 16'd0);
    chk("rst.valid", {15'd0, instr_valid}, 16'd0);
    chk("rst.ip", ip, RV);
    chk("rst.addr", mem_addr, RV);
    chk("rst.op", opcode, 16'h0000);
    chk("rst.imm", imm, 16'h0000);
    rst = 1'b0;
    chk("idle.req", {15'd0, mem_req}, 16'd0);
    @(negedge clk);

    pc = RV;
    for (int i = 0; i < 9; i++) begin
      run_instr($sformatf("t%0d", i), pc, tbl[i].w0, tbl[i].w1,
                tbl[i].exp_imm, tbl[i].nip, tbl[i].nip2,
                tbl[i].wait0, tbl[i].wait1, tbl[i].edelay);
      pc = tbl[i].exp_next;
    end

    // Abort during the immediate fetch.
    fetch_word("ab.op", pc, 16'hE123, 0, 1'b1);
    chk("ab.req", {15'd0, mem_req}, 16'd1);
    chk("ab.addr", mem_addr, 16'h0002);
    #2 rst = 1'b1;
    #1;
    chk("ab.valid", {15'd0, instr_valid}, 16'd0);
    chk("ab.rreq", {15'd0, mem_req}, 16'd0);
    chk("ab.ip", ip, RV);
    chk("ab.raddr", mem_addr, RV);
    chk("ab.op0", opcode, 16'h0000);
    chk("ab.imm0", imm, 16'h0000);
    cur_op  = 16'h0000;
    cur_imm = 16'h0000;
    @(negedge clk);
    rst = 1'b0;
    chk("ab.idle", {15'd0, mem_req}, 16'd0);
    @(negedge clk);

    // Random traffic against an instruction-level model.
    pc = RV;
    for (int n = 0; n < 150; n++) begin
      logic [15:0] w0, w1, nip, nip2, eimm, nxt;
      logic two;
      w0   = 16'($urandom);
      w1   = 16'($urandom);
      nip  = 16'($urandom);
      nip2 = ($urandom_range(0, 1) == 1) ? pc + 16'd1
                                         : 16'($urandom);
      two  = (w0[15:12] == 4'hE) || (w0[15:12] == 4'hF);
      eimm = two ? w1 : 16'h0000;
      nxt  = (w0[15:12] >= 4'hC) ? nip : nip2;
      run_instr($sformatf("r%0d", n), pc, w0, w1, eimm, nip, nip2,
                $urandom_range(0, 3), $urandom_range(0, 3),
                $urandom_range(0, 2));
      pc = nxt;
    end
    chk("final.req", {15'd0, mem_req}, 16'd1);
    chk("final.addr", mem_addr, pc);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction-fetch and program-counter stage of the 16-bit CPU. It owns the instruction pointer, reads one- or two-word instructions from program memory over a request/acknowledge handshake, and presents `opcode`, `imm` and `ip` to the control and execute logic. On execute completion it commits the next IP: for control-flow opcodes it takes the branch target from the control block, otherwise the sequential address.

## Interface
Parameters:
- `RESET_VECTOR`, default 16'h0000: IP value loaded on reset.

Ports:
- `clk` in 1: the single clock; all state updates on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `mem_req` out 1: program-memory read request.
- `mem_addr` out 16: read address; stable while `mem_req`=1.
- `mem_ack` in 1: read data valid this cycle.
- `mem_rdata` in 16: read data, sampled only when `mem_req`&&`mem_ack`.
- `ip` out 16: address of the issued instruction.
- `opcode` out 16: first instruction word.
- `imm` out 16: second word for opcodes 1110/1111; 0 otherwise.
- `instr_valid` out 1: `opcode`/`imm`/`ip` valid for execute.
- `exec_done` in 1: execute finished with the issued instruction.
- `next_ip` in 16: branch/jump target from the control block.
- `next_ip2` in 16: IP+1 from the control block.

## Operation
- States: IDLE, FETCH_OP, FETCH_IMM, ISSUE.
- Reset (async): state=IDLE, `ip`=RESET_VECTOR, `opcode`=0, `imm`=0, `instr_valid`=0, `mem_req`=0, `mem_addr`=`ip`.
- IDLE → FETCH_OP unconditionally on the first edge after reset release.
- FETCH_OP: `mem_req`=1, `mem_addr`=`ip`. On `mem_ack`, latch `opcode`=`mem_rdata`. If `mem_rdata[15:12]` is 1110 or 1111, go to FETCH_IMM. Otherwise clear `imm` to 0 and go to ISSUE.
- FETCH_IMM: `mem_req`=1, `mem_addr`=`ip`+1 (16-bit, wraps FFFF→0000). On `mem_ack`, latch `imm`=`mem_rdata` and go to ISSUE.
- ISSUE: `instr_valid`=1, `mem_req`=0. On `exec_done`, go to FETCH_OP and update `ip`:
  - If `opcode[15:12]` ∈ {1100, 1101, 1110, 1111}, `ip`=`next_ip`.
  - Otherwise `ip`=`next_ip2`.
- Ignored inputs:
  - `mem_ack` while `mem_req`=0.
  - `exec_done` outside ISSUE.
  - `next_ip`/`next_ip2` outside the `exec_done` edge.
- `opcode` and `imm` hold their values from issue until the next successful fetch.
- Reset asserted mid-fetch or mid-issue aborts immediately: no latch, IP back to RESET_VECTOR.

## Timing
- `mem_req`, `mem_addr` and `instr_valid` are decoded from registered state only (Moore); no combinational path from any input.
- `mem_ack` may arrive in the first cycle of the request (zero wait) or any later cycle. `mem_req` stays high until acked.
- One-word instruction, zero-wait memory: FETCH_OP 1 cycle, ISSUE ≥1 cycle. Back-to-back throughput is 2 cycles/instruction with `exec_done` held high.
- Two-word instruction: 3 cycles minimum.
- `exec_done` in the first ISSUE cycle is legal. The next FETCH_OP starts the following cycle using the new `ip`.
- `next_ip`/`next_ip2` are sampled on the edge where ISSUE && `exec_done`. They must be valid then, combinational from `ip`/`opcode`/`imm` plus the flags.

## Structure
- Shared package `cpu_pkg`:
  - Opcode field constants OP_BR=4'b1100, OP_JMP=4'b1101, OP_JMPI=4'b1110, OP_CALL=4'b1111.
  - Function `is_two_word(op[3:0])`.
  - Function `is_ctrl(op[3:0])`.
  - Fetch state enum.
- No sub-module: the FSM and registers form one module of roughly 150–200 lines.

## Test plan
- Reset release with RESET_VECTOR=16'h0100, zero-wait memory holding 16'h1234 at 0100 → cycle 1 `mem_req`=1, `mem_addr`=0100; cycle 2 `instr_valid`=1, `opcode`=1234, `imm`=0; on `exec_done` with `next_ip2`=0101 → next `mem_addr`=0101.
- Two-word instruction: mem[0200]=16'hE000, mem[0201]=16'h0ABC → addresses 0200 then 0201; `imm`=0ABC; on `exec_done` with `next_ip`=0ABC → fetch from 0ABC.
- Wait states: `mem_ack` delayed 3 cycles → `mem_req`/`mem_addr` held constant 4 cycles, `opcode` unchanged until the ack edge, `instr_valid`=0 throughout.
- Wrap: `ip`=FFFF, `opcode`=F000 → FETCH_IMM address is 0000; sequential opcode 16'h1000 at FFFF with `next_ip2`=0000 → next fetch at 0000.
- Branch select: `opcode`=C9xx, `next_ip`=0050, `next_ip2`=0011 → `ip`=0050. Then `opcode`=2xxx with the same inputs → `ip`=0011.
- Async reset asserted mid FETCH_IMM → immediately `instr_valid`=0, `mem_req`=0, `ip`=RESET_VECTOR; fetch restarts 2 cycles after release.
